// File: rtl/fsm_motor_responder_if.sv
// Handshake and configuration bundle between the motor controller side and
// the plant-side responder.
interface fsm_motor_responder_if #(
  parameter int GAP_W = 4
);
  logic             f;
  logic             g;
  logic [GAP_W-1:0] cfg_gap;
  logic [1:0]       cfg_ydly;
  logic             cfg_yen;
  logic             x;
  logic             y;
  logic             busy;
  logic             verdict_valid;
  logic             verdict_pass;
  logic             err_f;

  modport master (
    output f, g, cfg_gap, cfg_ydly, cfg_yen,
    input  x, y, busy, verdict_valid, verdict_pass, err_f
  );

  modport slave (
    input  f, g, cfg_gap, cfg_ydly, cfg_yen,
    output x, y, busy, verdict_valid, verdict_pass, err_f
  );
endinterface

// File: rtl/fsm_motor_responder.sv
// Plant-side responder: answers the controller's f pulse with the x=1,0,1
// pattern, replies to g with y, and judges whether g held through a window.
module fsm_motor_responder #(
  parameter int GAP_W     = 4,
  parameter int G_TIMEOUT = 4,
  parameter int OBS_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  fsm_motor_responder_if.slave bus
);

  localparam int CW = (GAP_W > 4) ? GAP_W : 4;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] TMO_LAST = CW'(G_TIMEOUT - 1);
  localparam logic [CW-1:0] OBS_LAST = CW'(OBS_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAP,
    S_X1,
    S_X0,
    S_X1B,
    S_WAIT_G,
    S_YDLY,
    S_Y_HOLD,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ydly;
  logic          r_yen;
  logic          r_gfail;
  logic          r_x;
  logic          r_y;
  logic          r_busy;
  logic          r_vv;
  logic          r_vp;
  logic          r_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ydly  <= '0;
      r_yen   <= 1'b0;
      r_gfail <= 1'b0;
      r_x     <= 1'b0;
      r_y     <= 1'b0;
      r_busy  <= 1'b0;
      r_vv    <= 1'b0;
      r_vp    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_vv <= 1'b0;
      if (bus.f && (r_state != S_IDLE))
        r_err <= 1'b1;

      // Outputs are registered alongside the state so each one tracks the
      // state being entered, not the one being left.
      case (r_state)
        S_IDLE: begin
          if (bus.f) begin
            r_ydly <= bus.cfg_ydly;
            r_yen  <= bus.cfg_yen;
            r_vp   <= 1'b0;
            r_busy <= 1'b1;
            if (bus.cfg_gap != '0) begin
              r_state <= S_GAP;
              r_cnt   <= CW'(bus.cfg_gap);
            end else begin
              r_state <= S_X1;
              r_x     <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (r_cnt == CNT_ONE) begin
            r_state <= S_X1;
            r_x     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_X1: begin
          r_state <= S_X0;
          r_x     <= 1'b0;
        end

        S_X0: begin
          r_state <= S_X1B;
          r_x     <= 1'b1;
        end

        S_X1B: begin
          r_state <= S_WAIT_G;
          r_x     <= 1'b0;
          r_cnt   <= '0;
        end

        S_WAIT_G: begin
          if (bus.g) begin
            if (r_ydly != 2'd0) begin
              r_state <= S_YDLY;
              r_cnt   <= CW'(r_ydly);
            end else begin
              r_state <= S_Y_HOLD;
              r_y     <= r_yen;
              r_cnt   <= '0;
              r_gfail <= 1'b0;
            end
          end else if (r_cnt == TMO_LAST) begin
            r_state <= S_DONE;
            r_vv    <= 1'b1;
            r_vp    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_YDLY: begin
          if (r_cnt == CNT_ONE) begin
            r_state <= S_Y_HOLD;
            r_y     <= r_yen;
            r_cnt   <= '0;
            r_gfail <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_Y_HOLD: begin
          // The final window sample is folded straight into the verdict.
          if (r_cnt == OBS_LAST) begin
            r_state <= S_DONE;
            r_y     <= 1'b0;
            r_vv    <= 1'b1;
            r_vp    <= ~r_gfail & bus.g;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (!bus.g)
              r_gfail <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_x     <= 1'b0;
          r_y     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x             = r_x;
  assign bus.y             = r_y;
  assign bus.busy          = r_busy;
  assign bus.verdict_valid = r_vv;
  assign bus.verdict_pass  = r_vp;
  assign bus.err_f         = r_err;

endmodule

// File: tb/tb_fsm_motor_responder.sv
// Randomized episodes against a timeline model of the responder, with a
// simple reference controller model driving g in closed loop.
module tb_fsm_motor_responder;

  localparam int GAP_W     = 4;
  localparam int G_TIMEOUT = 4;
  localparam int OBS_CYC   = 4;
  localparam int N         = 36;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fsm_motor_responder_if #(.GAP_W(GAP_W)) bus();

  fsm_motor_responder #(
    .GAP_W    (GAP_W),
    .G_TIMEOUT(G_TIMEOUT),
    .OBS_CYC  (OBS_CYC)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int ep    = 0;
  bit err_model = 1'b0;
  bit vp_hold   = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // {x, y, busy, verdict_valid, verdict_pass, err_f}
  function automatic logic [5:0] outs();
    return {bus.x, bus.y, bus.busy, bus.verdict_valid, bus.verdict_pass, bus.err_f};
  endfunction

  // mode 0: controller model, 1: g tied low, 2: random g.
  // finj>0: extra f pulse in that cycle. rst_at>=0: resetn low in that cycle.
  task automatic run_ep(input int gap, input int ydly, input bit yen,
                        input int mode, input int finj, input int rst_at);
    logic [5:0] obs [N];
    bit         gs  [N];
    int         ctl;
    bit         gv;
    int         w, k, ylo, yhi, done;
    bit         pass;
    bit         ex, ey, eb, ev, evp, ee;
    logic [5:0] e;
    ctl = 0;
    for (int i = 0; i < N; i++) begin
      @(posedge clk);
      #1;
      obs[i] = outs();
      bus.f  = (i == 0) || (finj > 0 && i == finj);
      resetn = !(rst_at >= 0 && i == rst_at);
      if (i == 0) begin
        bus.cfg_gap  = GAP_W'(gap);
        bus.cfg_ydly = 2'(ydly);
        bus.cfg_yen  = yen;
      end else begin
        bus.cfg_gap  = GAP_W'($urandom_range(0, 15));
        bus.cfg_ydly = 2'($urandom_range(0, 3));
        bus.cfg_yen  = 1'($urandom_range(0, 1));
      end
      gv = 1'b0;
      case (mode)
        0: begin
          case (ctl)
            0: if (i >= 3 && obs[i-1][5] && !obs[i-2][5] && obs[i-3][5]) begin
                 gv  = 1'b1;
                 ctl = 1;
               end
            1: begin
                 gv  = obs[i][4];
                 ctl = obs[i][4] ? 2 : 3;
               end
            2: if (obs[i][2]) ctl = 3;
               else gv = 1'b1;
            default: gv = 1'b0;
          endcase
        end
        1:       gv = 1'b0;
        default: gv = 1'($urandom_range(0, 1));
      endcase
      bus.g = gv;
      gs[i] = gv;
    end

    w = gap + 4;
    k = -1;
    for (int j = w; j < w + G_TIMEOUT; j++)
      if (k < 0 && gs[j]) k = j;
    if (k < 0) begin
      done = w + G_TIMEOUT;
      pass = 1'b0;
      ylo  = N;
      yhi  = -1;
    end else begin
      ylo  = k + 1 + ydly;
      yhi  = ylo + OBS_CYC - 1;
      done = yhi + 1;
      pass = 1'b1;
      for (int j = ylo; j <= yhi; j++)
        if (!gs[j]) pass = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      if (rst_at >= 0 && i > rst_at) begin
        e = '0;
      end else begin
        ex  = (i == gap + 1) || (i == gap + 3);
        ey  = yen && (i >= ylo) && (i <= yhi);
        eb  = (i >= 1) && (i <= done);
        ev  = (i == done);
        evp = (i == 0) ? vp_hold : ((i >= done) ? pass : 1'b0);
        ee  = err_model || (finj > 0 && i > finj);
        e   = {ex, ey, eb, ev, evp, ee};
      end
      chk($sformatf("ep%0d_c%0d", ep, i), {2'b00, obs[i]}, {2'b00, e});
    end

    if (rst_at >= 0) begin
      err_model = 1'b0;
      vp_hold   = 1'b0;
    end else begin
      vp_hold = pass;
      if (finj > 0) err_model = 1'b1;
    end
    ep++;
  endtask

  initial begin
    int gap, ydly, mode, finj, rst_at;
    bit yen;
    resetn       = 1'b0;
    bus.f        = 1'b0;
    bus.g        = 1'b0;
    bus.cfg_gap  = '0;
    bus.cfg_ydly = '0;
    bus.cfg_yen  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {2'b00, outs()}, 8'h00);
    resetn = 1'b1;

    run_ep(0, 0, 1'b1, 0, 0, -1);   // fastest pass
    run_ep(3, 0, 1'b1, 0, 0, -1);   // gap shift
    run_ep(0, 1, 1'b1, 0, 0, -1);   // late y -> fail
    run_ep(0, 0, 1'b0, 0, 0, -1);   // y disabled -> fail
    run_ep(0, 0, 1'b1, 1, 0, -1);   // g tied low -> timeout
    run_ep(0, 0, 1'b1, 0, 2, -1);   // f during X0 sets err_f
    run_ep(2, 0, 1'b1, 0, 0, -1);   // err_f stays set
    run_ep(0, 0, 1'b1, 0, 0, 6);    // reset during Y_HOLD
    run_ep(0, 0, 1'b1, 0, 0, -1);   // clean restart
    run_ep(0, 0, 1'b1, 0, 0, 0);    // reset beats f
    run_ep(15, 3, 1'b1, 2, 9, -1);  // largest gap and delay

    for (int n = 0; n < 60; n++) begin
      gap    = $urandom_range(0, 15);
      ydly   = $urandom_range(0, 3);
      yen    = 1'($urandom_range(0, 1));
      mode   = $urandom_range(0, 2);
      finj   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
      rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : -1;
      if (rst_at >= 0 && finj >= rst_at) finj = 0;
      run_ep(gap, ydly, yen, mode, finj, rst_at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
